// File: rtl/dwc_downconv_cmd_prefetch_rd_if.sv
// -----------------------------------------------------------------------------
// dwc_downconv_cmd_prefetch_rd_if
//
// Groups the signals between the read command FIFO, the read command prefetch
// queue and the down-converter read control FSM.
//
// Signals:
//   cmd_in             head word of the source FIFO (valid while cmd_fifo_empty=0)
//   cmd_fifo_empty     source FIFO empty
//   get_next           consumer pops the head entry
//   cmd_fifo_rd_en     prefetch queue pops the source FIFO this cycle
//   cmd_out            head entry, raw command word
//   q_empty / q_full   queue has no valid head / queue holds DEPTH entries
//   mask_mstSize .. sizeCnt_EQ_SizeMax   precomputed decode fields of the head
//   size_err           head slave size larger than master size (0 if not built)
//
// Modports:
//   master  environment side (source FIFO plus consumer)
//   slave   prefetch queue side
// -----------------------------------------------------------------------------
interface dwc_downconv_cmd_prefetch_rd_if #(
    parameter int CMD_FIFO_DATA_WIDTH = 29,
    parameter int AW                  = 6
) ();
    logic [CMD_FIFO_DATA_WIDTH-1:0] cmd_in;
    logic                           cmd_fifo_empty;
    logic                           get_next;
    logic                           cmd_fifo_rd_en;
    logic [CMD_FIFO_DATA_WIDTH-1:0] cmd_out;
    logic                           q_empty;
    logic                           q_full;
    logic [AW-1:0]                  mask_mstSize;
    logic [AW-1:0]                  mask_slvSize;
    logic [AW-1:0]                  master_ADDR_masked;
    logic [AW-1:0]                  second_Beat_Addr;
    logic [AW-1:0]                  sizeCnt_P1;
    logic [AW-1:0]                  sizeMax_extend;
    logic [AW:0]                    slaveSize_one_hot;
    logic                           sizeCnt_EQ_SizeMax;
    logic                           size_err;

    modport master (
        output cmd_in, cmd_fifo_empty, get_next,
        input  cmd_fifo_rd_en, cmd_out, q_empty, q_full,
        input  mask_mstSize, mask_slvSize, master_ADDR_masked, second_Beat_Addr,
        input  sizeCnt_P1, sizeMax_extend, slaveSize_one_hot, sizeCnt_EQ_SizeMax,
        input  size_err
    );

    modport slave (
        input  cmd_in, cmd_fifo_empty, get_next,
        output cmd_fifo_rd_en, cmd_out, q_empty, q_full,
        output mask_mstSize, mask_slvSize, master_ADDR_masked, second_Beat_Addr,
        output sizeCnt_P1, sizeMax_extend, slaveSize_one_hot, sizeCnt_EQ_SizeMax,
        output size_err
    );
endinterface

// File: rtl/dwc_downconv_cmd_prefetch_rd.sv
// -----------------------------------------------------------------------------
// dwc_downconv_cmd_prefetch_rd
//
// DEPTH-entry prefetch queue for read commands of the AXI4 data-width
// down-converter. Commands are popped from a show-ahead FIFO ahead of need and
// stored together with their address/size decode, so the read control FSM only
// ever sees registered decode values.
//
// Ports:
//   ACLK      clock
//   sysReset  asynchronous, active-high reset
//   bus       dwc_downconv_cmd_prefetch_rd_if.slave (command in, FIFO pop,
//             consumer pop, head command and decode fields out)
//
// Optional feature macro: DWC_DOWNCONV_RD_SIZE_CHECK_EN
//   defined     each entry stores size_err = (slave size > master size)
//   undefined   size_err is tied to 0, no storage bit and no comparator
// -----------------------------------------------------------------------------
module dwc_downconv_cmd_prefetch_rd #(
    parameter int CMD_FIFO_DATA_WIDTH = 29,
    parameter int ID_WIDTH            = 29,
    parameter int AW                  = 6,
    parameter int DEPTH               = 2
) (
    input  logic                          ACLK,
    input  logic                          sysReset,
    dwc_downconv_cmd_prefetch_rd_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Fields may sit above the raw word for some parameter sets; those bits read 0.
    localparam int FIELD_TOP = 30 + ID_WIDTH + AW;
    localparam int EXT_W = (CMD_FIFO_DATA_WIDTH > FIELD_TOP) ? CMD_FIFO_DATA_WIDTH : FIELD_TOP;

    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [AW-1:0]    AW_ONE     = AW'(1);
    localparam logic [AW:0]      AW1_ONE    = (AW+1)'(1);

    typedef struct packed {
        logic [CMD_FIFO_DATA_WIDTH-1:0] cmd;
        logic [AW-1:0]                  mask_mst;
        logic [AW-1:0]                  mask_slv;
        logic [AW-1:0]                  addr_masked;
        logic [AW-1:0]                  second_beat;
        logic [AW-1:0]                  size_cnt_p1;
        logic [AW-1:0]                  size_max_ext;
        logic [AW:0]                    slv_one_hot;
        logic                           cnt_eq_max;
`ifdef DWC_DOWNCONV_RD_SIZE_CHECK_EN
        logic                           size_err;
`endif
    } entry_t;

    entry_t           storage_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             q_empty_r;
    logic             q_full_r;

    logic [EXT_W-1:0] cmd_ext_s;
    logic [2:0]       m_sz_s;
    logic [2:0]       s_sz_s;
    logic [AW-1:0]    size_max_s;
    logic [AW-1:0]    addr_s;
    logic [AW-1:0]    size_cnt_s;
    logic [AW-1:0]    m_low_s;
    logic [AW-1:0]    s_low_s;
    entry_t           new_entry_s;

    logic             pop_s;
    logic             push_s;
    logic [CNT_W-1:0] count_next_s;
    entry_t           head_s;

    // Field extraction and decode of the source head word, captured on push.
    always_comb begin
        cmd_ext_s                               = '0;
        cmd_ext_s[CMD_FIFO_DATA_WIDTH-1:0]      = bus.cmd_in;
        m_sz_s     = cmd_ext_s[10:8];
        s_sz_s     = cmd_ext_s[13:11];
        size_max_s = cmd_ext_s[AW:1];
        addr_s     = cmd_ext_s[23 +: AW];
        size_cnt_s = cmd_ext_s[30+ID_WIDTH +: AW];

        // Low-bit masks below each size; wrap modulo 2^AW for large sizes.
        m_low_s = (AW_ONE << m_sz_s) - AW_ONE;
        s_low_s = (AW_ONE << s_sz_s) - AW_ONE;

        new_entry_s              = '0;
        new_entry_s.cmd          = bus.cmd_in;
        new_entry_s.mask_mst     = m_low_s & ~s_low_s;
        new_entry_s.mask_slv     = ~s_low_s;
        new_entry_s.addr_masked  = addr_s & ~m_low_s;
        new_entry_s.second_beat  = addr_s + (AW_ONE << s_sz_s);
        new_entry_s.size_cnt_p1  = size_cnt_s + AW_ONE;
        new_entry_s.slv_one_hot  = AW1_ONE << s_sz_s;
        new_entry_s.size_max_ext = size_max_s << s_sz_s;
        new_entry_s.cnt_eq_max   = (size_cnt_s == size_max_s);
`ifdef DWC_DOWNCONV_RD_SIZE_CHECK_EN
        new_entry_s.size_err     = (s_sz_s > m_sz_s);
`endif
    end

    // Push/pop decision and occupancy update; a full queue may refill while popping.
    always_comb begin
        pop_s        = bus.get_next & ~q_empty_r;
        push_s       = ~bus.cmd_fifo_empty & ((count_r != DEPTH_CNT) | pop_s);
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers, occupancy and registered status flags.
    always_ff @(posedge ACLK or posedge sysReset) begin
        if (sysReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage_r[i] <= '0;
            end
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            q_empty_r <= 1'b1;
            q_full_r  <= 1'b0;
        end else begin
            if (push_s) begin
                storage_r[wr_ptr_r] <= new_entry_s;
                wr_ptr_r            <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r   <= count_next_s;
            q_empty_r <= (count_next_s == '0);
            q_full_r  <= (count_next_s == DEPTH_CNT);
        end
    end

    assign head_s = storage_r[rd_ptr_r];

    assign bus.cmd_fifo_rd_en     = push_s;
    assign bus.q_empty            = q_empty_r;
    assign bus.q_full             = q_full_r;
    assign bus.cmd_out            = head_s.cmd;
    assign bus.mask_mstSize       = head_s.mask_mst;
    assign bus.mask_slvSize       = head_s.mask_slv;
    assign bus.master_ADDR_masked = head_s.addr_masked;
    assign bus.second_Beat_Addr   = head_s.second_beat;
    assign bus.sizeCnt_P1         = head_s.size_cnt_p1;
    assign bus.sizeMax_extend     = head_s.size_max_ext;
    assign bus.slaveSize_one_hot  = head_s.slv_one_hot;
    assign bus.sizeCnt_EQ_SizeMax = head_s.cnt_eq_max;
`ifdef DWC_DOWNCONV_RD_SIZE_CHECK_EN
    assign bus.size_err           = head_s.size_err;
`else
    assign bus.size_err           = 1'b0;
`endif

endmodule

// File: tb/tb_dwc_downconv_cmd_prefetch_rd.sv
module tb_dwc_downconv_cmd_prefetch_rd;
    localparam int ID_W  = 4;
    localparam int AW    = 6;
    localparam int DEPTH = 2;
    localparam int CW    = 30 + ID_W + AW;   // 40: sizeCnt field fits in the word

    logic ACLK;
    logic sysReset;

    dwc_downconv_cmd_prefetch_rd_if #(.CMD_FIFO_DATA_WIDTH(CW), .AW(AW)) bus ();

    dwc_downconv_cmd_prefetch_rd #(
        .CMD_FIFO_DATA_WIDTH(CW), .ID_WIDTH(ID_W), .AW(AW), .DEPTH(DEPTH)
    ) dut (
        .ACLK(ACLK), .sysReset(sysReset), .bus(bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [CW-1:0] src_q [$];   // source FIFO model
    logic [CW-1:0] exp_q [$];   // scoreboard: words accepted by the queue, in order
    logic          last_rd_en;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    function automatic logic [CW-1:0] make_cmd(input logic [2:0] msz, input logic [2:0] ssz,
                                               input logic [5:0] addr, input logic [5:0] smax,
                                               input logic [5:0] scnt);
        logic [CW-1:0] w;
        w = '0;
        w[10:8]  = msz;
        w[13:11] = ssz;
        w[6:1]   = smax;
        w[28:23] = addr;
        w[39:34] = scnt;
        w[0]     = 1'b1;
        w[33:30] = 4'hA;
        return w;
    endfunction

    // One clock: drive source/consumer, compare popped head, then update model.
    task automatic cycle(input logic gn);
        logic popping;
        logic [CW-1:0] e;
        bus.get_next       = gn;
        bus.cmd_fifo_empty = (src_q.size() == 0);
        bus.cmd_in         = (src_q.size() == 0) ? '0 : src_q[0];
        @(negedge ACLK);
        last_rd_en = bus.cmd_fifo_rd_en;
        popping    = gn & ~bus.q_empty;
        if (popping) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_pop popped with empty scoreboard, cmd_out=%h", bus.cmd_out);
            end else begin
                e = exp_q.pop_front();
                if (bus.cmd_out !== e) begin
                    failures++;
                    $display("FAIL sb_order cmd_out got=%h exp=%h", bus.cmd_out, e);
                end
            end
        end
        @(posedge ACLK);
        #1;
        if (last_rd_en) exp_q.push_back(src_q.pop_front());
        checks++;
        if (bus.q_empty !== (exp_q.size() == 0) || bus.q_full !== (exp_q.size() == DEPTH)) begin
            failures++;
            $display("FAIL occupancy empty/full got=%b/%b exp_count=%0d",
                     bus.q_empty, bus.q_full, exp_q.size());
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cycle(1'b1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout remaining=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (bus.q_empty !== 1'b1 || bus.q_full !== 1'b0 || bus.cmd_fifo_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL %s flags empty/full/rd_en got=%b%b%b exp=100", tag,
                     bus.q_empty, bus.q_full, bus.cmd_fifo_rd_en);
        end
        checks++;
        if ({bus.cmd_out, bus.mask_mstSize, bus.mask_slvSize, bus.master_ADDR_masked,
             bus.second_Beat_Addr, bus.sizeCnt_P1, bus.sizeMax_extend, bus.slaveSize_one_hot,
             bus.sizeCnt_EQ_SizeMax, bus.size_err} !== '0) begin
            failures++;
            $display("FAIL %s outputs cmd_out=%h mst=%h slv=%h msk=%h sba=%h p1=%h ext=%h oh=%h eq=%b got nonzero exp=0",
                     tag, bus.cmd_out, bus.mask_mstSize, bus.mask_slvSize, bus.master_ADDR_masked,
                     bus.second_Beat_Addr, bus.sizeCnt_P1, bus.sizeMax_extend,
                     bus.slaveSize_one_hot, bus.sizeCnt_EQ_SizeMax);
        end
    endtask

    task automatic test_reset();
        sysReset = 1'b1;
        bus.get_next = 1'b0; bus.cmd_fifo_empty = 1'b1; bus.cmd_in = '0;
        repeat (3) @(negedge ACLK);
        check_reset_state("reset");
        sysReset = 1'b0;
        @(posedge ACLK); #1;
    endtask

    task automatic test_single_cmd();
        src_q.push_back(make_cmd(3'd3, 3'd1, 6'h0D, 6'd3, 6'd3));
        cycle(1'b0);
        checks++;
        if (last_rd_en !== 1'b1 || bus.q_empty !== 1'b0) begin
            failures++;
            $display("FAIL single_latency rd_en/q_empty got=%b/%b exp=1/0", last_rd_en, bus.q_empty);
        end
        checks++;
        if (bus.mask_mstSize !== 6'h06 || bus.mask_slvSize !== 6'h3E) begin
            failures++;
            $display("FAIL single_masks mst/slv got=%h/%h exp=06/3e", bus.mask_mstSize, bus.mask_slvSize);
        end
        checks++;
        if (bus.master_ADDR_masked !== 6'h08 || bus.second_Beat_Addr !== 6'h0F) begin
            failures++;
            $display("FAIL single_addr masked/second got=%h/%h exp=08/0f",
                     bus.master_ADDR_masked, bus.second_Beat_Addr);
        end
        checks++;
        if (bus.slaveSize_one_hot !== 7'h02 || bus.sizeMax_extend !== 6'h06) begin
            failures++;
            $display("FAIL single_size onehot/ext got=%h/%h exp=02/06",
                     bus.slaveSize_one_hot, bus.sizeMax_extend);
        end
        checks++;
        if (bus.sizeCnt_P1 !== 6'd4 || bus.sizeCnt_EQ_SizeMax !== 1'b1) begin
            failures++;
            $display("FAIL single_cnt p1/eq got=%0d/%b exp=4/1", bus.sizeCnt_P1, bus.sizeCnt_EQ_SizeMax);
        end
        drain();
    endtask

    task automatic test_wrap_arith();
        src_q.push_back(make_cmd(3'd0, 3'd1, 6'h3F, 6'd0, 6'h3F));
        cycle(1'b0);
        checks++;
        if (bus.second_Beat_Addr !== 6'h01 || bus.sizeCnt_P1 !== 6'h00 || bus.sizeCnt_EQ_SizeMax !== 1'b0) begin
            failures++;
            $display("FAIL wrap second/p1/eq got=%h/%h/%b exp=01/00/0",
                     bus.second_Beat_Addr, bus.sizeCnt_P1, bus.sizeCnt_EQ_SizeMax);
        end
        drain();
    endtask

    task automatic test_size_err();
        logic exp_err;
`ifdef DWC_DOWNCONV_RD_SIZE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        src_q.push_back(make_cmd(3'd2, 3'd3, 6'h10, 6'd1, 6'd2));
        cycle(1'b0);
        checks++;
        if (bus.size_err !== exp_err) begin
            failures++;
            $display("FAIL size_err got=%b exp=%b", bus.size_err, exp_err);
        end
        drain();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 3; i++) src_q.push_back(make_cmd(3'(i), 3'd0, 6'(i * 5), 6'(i), 6'(7 - i)));
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b0);
        checks++;
        if (last_rd_en !== 1'b0 || bus.q_full !== 1'b1 || src_q.size() != 1) begin
            failures++;
            $display("FAIL fill_full rd_en/q_full/src_left got=%b/%b/%0d exp=0/1/1",
                     last_rd_en, bus.q_full, src_q.size());
        end
        cycle(1'b1);
        checks++;
        if (last_rd_en !== 1'b1 || bus.q_full !== 1'b1 || src_q.size() != 0) begin
            failures++;
            $display("FAIL fill_pushpop rd_en/q_full/src_left got=%b/%b/%0d exp=1/1/0",
                     last_rd_en, bus.q_full, src_q.size());
        end
        drain();
    endtask

    task automatic test_streaming();
        int hi = 0;
        for (int i = 0; i < 16; i++) src_q.push_back(make_cmd(3'($urandom_range(7)), 3'($urandom_range(7)),
                                                            6'($urandom_range(63)), 6'(i), 6'($urandom_range(63))));
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1);
            if (last_rd_en === 1'b1) hi++;
        end
        checks++;
        if (hi != 16) begin
            failures++;
            $display("FAIL stream_rd_en high_cycles got=%0d exp=16", hi);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) src_q.push_back(make_cmd(3'd5, 3'd2, 6'h2A, 6'd9, 6'd9));
        cycle(1'b0);
        cycle(1'b0);
        #2;
        src_q.delete();
        exp_q.delete();
        bus.cmd_fifo_empty = 1'b1;
        bus.cmd_in = '0;
        bus.get_next = 1'b0;
        sysReset = 1'b1;
        #1;
        check_reset_state("reset_mid");
        @(negedge ACLK);
        sysReset = 1'b0;
        @(posedge ACLK); #1;
        check_reset_state("post_reset");
    endtask

    initial begin
        test_reset();
        test_single_cmd();
        test_wrap_arith();
        test_size_err();
        test_fill();
        test_streaming();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
